// File: rtl/control_sequencer.sv
// Purpose: hardwired control sequencer that emits one state of datapath strobes per clock (fetch + execute).
// Latency: fetch is 3+MEM_WAIT clocks, execute is 0..5+MEM_WAIT more; the strobes are a Moore decode of state and the latched opcode.
// Backpressure: none is taken from downstream; run gates the start of each fetch, and each memory state holds for 1+MEM_WAIT clocks.
// Ports: clk/clear (sync active-high reset), run, IR (opcode in IR[31:27]);
//   PC, memory, datapath, register-select and ALU strobes; halted, illegal (T2 pulse), instr_count, step (state code).
module control_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             Write,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Cout,
  output logic             BAout,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             ADD,
  output logic             SUB,
  output logic             AND,
  output logic             OR,
  output logic             SHR,
  output logic             SHL,
  output logic             ROR,
  output logic             ROL,
  output logic             NEG,
  output logic             NOT,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       step
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd15;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_NOP  = 5'd24;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  logic [3:0] state, state_nxt;
  logic [3:0] wcnt;
  logic [4:0] opc;
  logic [4:0] ir_op;
  logic       retire, eoi, op_en;
  logic       is_ld, is_ldi, is_st, is_alu2, is_un;
  logic       wait_done, first_t1;
  logic       unused_ir_bits;

  function automatic logic op_legal(input logic [4:0] op);
    return op inside {[5'd0:5'd10], 5'd16, 5'd17, OP_NOP, OP_HALT};
  endfunction

  assign ir_op          = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  assign is_ld    = (opc == OP_LD);
  assign is_ldi   = (opc == OP_LDI);
  assign is_st    = (opc == OP_ST);
  assign is_alu2  = opc inside {[5'd3:5'd10]};
  assign is_un    = opc inside {5'd16, 5'd17};

  // wcnt is reloaded on every state change, so a memory state sees WAIT_INIT
  // in its first clock and advances once the count has run down to zero.
  assign wait_done = (wcnt == 4'd0);
  assign first_t1  = (wcnt == WAIT_INIT);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    eoi       = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (wait_done) state_nxt = S_T2;
      // T2 branches on the live IR image; opc only becomes valid in T3.
      S_T2: begin
        if (ir_op == OP_HALT)     state_nxt = S_HALT;
        else if (ir_op == OP_NOP) begin eoi = 1'b1; retire = 1'b1; end
        else if (!op_legal(ir_op)) eoi = 1'b1;
        else                       state_nxt = S_T3;
      end
      S_T3:   state_nxt = S_T4;
      S_T4:   if (is_un) begin eoi = 1'b1; retire = 1'b1; end else state_nxt = S_T5;
      S_T5:   if (is_ld || is_st) state_nxt = S_T6; else begin eoi = 1'b1; retire = 1'b1; end
      S_T6:   if (!is_ld || wait_done) state_nxt = S_T7;
      S_T7:   if (!is_st || wait_done) begin eoi = 1'b1; retire = 1'b1; end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    if (eoi) state_nxt = run ? S_T0 : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_IDLE;
      wcnt        <= 4'd0;
      opc         <= OP_NOP;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wcnt <= WAIT_INIT;
      else if (wcnt != 4'd0)  wcnt <= wcnt - 4'd1;
      if (state == S_T2) opc <= ir_op;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
     Zlowout, Cout, BAout, Gra, Grb, Grc, Rin, Rout} = '0;
    {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = '0;
    op_en = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; Zlowout = first_t1; PCin = first_t1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu2)    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_un) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; op_en = 1'b1; end
        else if (is_ld || is_ldi || is_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      end
      S_T4: begin
        if (is_un)        begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_alu2) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; op_en = 1'b1; end
        else if (is_ld || is_ldi || is_st) begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
      end
      S_T5: begin
        if (is_ld || is_st) begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (is_ldi || is_alu2) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6: begin
        if (is_ld)      begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
    if (op_en) begin
      case (opc)
        5'd3:  ADD = 1'b1;
        5'd4:  SUB = 1'b1;
        5'd5:  SHR = 1'b1;
        5'd6:  SHL = 1'b1;
        5'd7:  ROR = 1'b1;
        5'd8:  ROL = 1'b1;
        5'd9:  AND = 1'b1;
        5'd10: OR  = 1'b1;
        5'd16: NEG = 1'b1;
        5'd17: NOT = 1'b1;
        default: ;
      endcase
    end
  end

  assign step    = state;
  assign halted  = (state == S_HALT);
  assign illegal = (state == S_T2) && !op_legal(ir_op);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: three instances (MEM_WAIT 0/1/2, CNT_W 2/16/16) share stimulus.
// A per-instance queue of expected cycles is built from the instruction tables and checked every clock.
// Directed scenarios pin cycle counts and strobe counts with literal values, then randomized traffic runs.
module tb_control_sequencer;

  localparam int B_PCOUT = 0,  B_PCIN = 1,  B_INCPC = 2,  B_MARIN = 3,  B_MDRIN = 4;
  localparam int B_MDROUT = 5, B_READ = 6,  B_WRITE = 7,  B_IRIN = 8,   B_YIN = 9;
  localparam int B_ZIN = 10,   B_ZLOW = 11, B_COUT = 12,  B_BAOUT = 13, B_GRA = 14;
  localparam int B_GRB = 15,   B_GRC = 16,  B_RIN = 17,   B_ROUT = 18,  B_ADD = 19;
  localparam int B_SUB = 20,   B_AND = 21,  B_OR = 22,    B_SHR = 23,   B_SHL = 24;
  localparam int B_ROR = 25,   B_ROL = 26,  B_NEG = 27,   B_NOT = 28;

  typedef struct packed {
    logic [3:0]  step;
    logic [31:0] m;
    logic        t2;
    logic        retire;
  } rec_t;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [31:0] IR = 32'h0;

  wire [31:0] stb [3];
  wire [3:0]  step_w [3];
  wire [15:0] cnt_w [3];
  wire [2:0]  halted_w, ill_w;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 0) ? 2 : 16;
    logic [CW-1:0] ic;
    control_sequencer #(.MEM_WAIT(g), .CNT_W(CW)) dut (
      .clk(clk), .clear(clear), .run(run), .IR(IR),
      .PCout(stb[g][B_PCOUT]), .PCin(stb[g][B_PCIN]), .IncPC(stb[g][B_INCPC]),
      .MARin(stb[g][B_MARIN]), .MDRin(stb[g][B_MDRIN]), .MDRout(stb[g][B_MDROUT]),
      .Read(stb[g][B_READ]), .Write(stb[g][B_WRITE]), .IRin(stb[g][B_IRIN]),
      .Yin(stb[g][B_YIN]), .Zin(stb[g][B_ZIN]), .Zlowout(stb[g][B_ZLOW]),
      .Cout(stb[g][B_COUT]), .BAout(stb[g][B_BAOUT]), .Gra(stb[g][B_GRA]),
      .Grb(stb[g][B_GRB]), .Grc(stb[g][B_GRC]), .Rin(stb[g][B_RIN]), .Rout(stb[g][B_ROUT]),
      .ADD(stb[g][B_ADD]), .SUB(stb[g][B_SUB]), .AND(stb[g][B_AND]), .OR(stb[g][B_OR]),
      .SHR(stb[g][B_SHR]), .SHL(stb[g][B_SHL]), .ROR(stb[g][B_ROR]), .ROL(stb[g][B_ROL]),
      .NEG(stb[g][B_NEG]), .NOT(stb[g][B_NOT]),
      .halted(halted_w[g]), .illegal(ill_w[g]), .instr_count(ic), .step(step_w[g])
    );
    assign cnt_w[g] = 16'(ic);
    assign stb[g][31:29] = 3'b000;
  end

  task automatic check(input string nm, input int inst, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] bt(input int b);
    return 32'd1 << b;
  endfunction

  function automatic logic legal(input logic [4:0] op);
    return (op <= 5'd10) || op == 5'd16 || op == 5'd17 || op == 5'd24 || op == 5'd27;
  endfunction

  function automatic int opbit(input logic [4:0] op);
    case (op)
      5'd3: return B_ADD;   5'd4: return B_SUB;   5'd5: return B_SHR;  5'd6: return B_SHL;
      5'd7: return B_ROR;   5'd8: return B_ROL;   5'd9: return B_AND;  5'd10: return B_OR;
      5'd16: return B_NEG;  default: return B_NOT;
    endcase
  endfunction

  // ---------------- behavioural model: queue of expected cycles ----------------
  rec_t cur [3];
  rec_t qbuf [3][32];
  int   qh [3];
  int   qn [3];
  int   ecnt [3];
  bit   hmode [3];
  bit   chk = 1'b0;

  task automatic push(input int i, input logic [3:0] s, input logic [31:0] m,
                      input logic t2, input logic rt);
    rec_t r;
    r.step = s; r.m = m; r.t2 = t2; r.retire = rt;
    qbuf[i][(qh[i] + qn[i]) % 32] = r;
    qn[i]++;
  endtask

  // Instance i has MEM_WAIT == i, so every memory phase is i+1 cycles.
  task automatic adv(input int i);
    logic [4:0]  op;
    logic [31:0] ldx3, ldx4;
    rec_t        idle;
    idle = '0;
    if (clear) begin
      qn[i] = 0; qh[i] = 0; hmode[i] = 1'b0; ecnt[i] = 0; cur[i] = idle;
      return;
    end
    if (cur[i].retire) ecnt[i]++;
    if (cur[i].t2) begin
      op   = IR[31:27];
      ldx3 = bt(B_GRB) | bt(B_BAOUT) | bt(B_YIN);
      ldx4 = bt(B_COUT) | bt(B_ADD) | bt(B_ZIN);
      if (op == 5'd0) begin
        push(i, 4, ldx3, 0, 0); push(i, 5, ldx4, 0, 0);
        push(i, 6, bt(B_ZLOW) | bt(B_MARIN), 0, 0);
        for (int k = 0; k <= i; k++) push(i, 7, bt(B_READ) | bt(B_MDRIN), 0, 0);
        push(i, 8, bt(B_MDROUT) | bt(B_GRA) | bt(B_RIN), 0, 1);
      end else if (op == 5'd1) begin
        push(i, 4, ldx3, 0, 0); push(i, 5, ldx4, 0, 0);
        push(i, 6, bt(B_ZLOW) | bt(B_GRA) | bt(B_RIN), 0, 1);
      end else if (op == 5'd2) begin
        push(i, 4, ldx3, 0, 0); push(i, 5, ldx4, 0, 0);
        push(i, 6, bt(B_ZLOW) | bt(B_MARIN), 0, 0);
        push(i, 7, bt(B_GRA) | bt(B_ROUT) | bt(B_MDRIN), 0, 0);
        for (int k = 0; k <= i; k++) push(i, 8, bt(B_WRITE), 0, k == i);
      end else if (op >= 5'd3 && op <= 5'd10) begin
        push(i, 4, bt(B_GRB) | bt(B_ROUT) | bt(B_YIN), 0, 0);
        push(i, 5, bt(B_GRC) | bt(B_ROUT) | bt(B_ZIN) | bt(opbit(op)), 0, 0);
        push(i, 6, bt(B_ZLOW) | bt(B_GRA) | bt(B_RIN), 0, 1);
      end else if (op == 5'd16 || op == 5'd17) begin
        push(i, 4, bt(B_GRB) | bt(B_ROUT) | bt(B_ZIN) | bt(opbit(op)), 0, 0);
        push(i, 5, bt(B_ZLOW) | bt(B_GRA) | bt(B_RIN), 0, 1);
      end else if (op == 5'd24) begin
        ecnt[i]++;
      end else if (op == 5'd27) begin
        hmode[i] = 1'b1;
      end
    end
    if (qn[i] == 0 && !hmode[i] && run) begin
      push(i, 1, bt(B_PCOUT) | bt(B_MARIN) | bt(B_INCPC) | bt(B_ZIN), 0, 0);
      for (int k = 0; k <= i; k++)
        push(i, 2, bt(B_READ) | bt(B_MDRIN) | ((k == 0) ? (bt(B_ZLOW) | bt(B_PCIN)) : 32'd0), 0, 0);
      push(i, 3, bt(B_MDROUT) | bt(B_IRIN), 1, 0);
    end
    if (qn[i] > 0) begin
      cur[i] = qbuf[i][qh[i]];
      qh[i] = (qh[i] + 1) % 32;
      qn[i]--;
    end else if (hmode[i]) begin
      cur[i] = idle; cur[i].step = 4'd15;
    end else begin
      cur[i] = idle;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) adv(i);
    if (clear) chk <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 3; i++) begin
        check("step", i, step_w[i], cur[i].step);
        check("strobes", i, stb[i], cur[i].m);
        check("halted", i, halted_w[i], cur[i].step == 4'd15);
        check("illegal", i, ill_w[i], cur[i].t2 && !legal(IR[31:27]));
        check("instr_count", i, cnt_w[i], (i == 0) ? (ecnt[i] & 3) : (ecnt[i] & 16'hFFFF));
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [3:0]  st_log [3][40];
  logic [31:0] sb_log [3][40];
  logic [15:0] ct_log [3][40];
  logic        il_log [3][40];
  logic        hl_log [3][40];

  task automatic start(input logic [31:0] ir_v);
    @(negedge clk); #1;
    clear = 1'b1; IR = ir_v; run = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        st_log[i][k] = step_w[i]; sb_log[i][k] = stb[i];
        ct_log[i][k] = cnt_w[i];  il_log[i][k] = ill_w[i]; hl_log[i][k] = halted_w[i];
      end
    end
  endtask

  function automatic int count_bit(input int i, input int b, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (sb_log[i][k][b]) c++;
    return c;
  endfunction

  initial begin
    int   c, found;
    logic [4:0] op;
    // reset state
    @(negedge clk); #1;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_step", i, step_w[i], 0);
      check("rst_count", i, cnt_w[i], 0);
      check("rst_strobes", i, stb[i], 0);
    end

    // ld R1,0x85
    start(32'h00800085);
    capture(14);
    check("ld_w0_T7", 0, st_log[0][7], 8);
    check("ld_w0_next_T0", 0, st_log[0][8], 1);
    check("ld_w0_cnt_before", 0, ct_log[0][7], 0);
    check("ld_w0_cnt_after", 0, ct_log[0][8], 1);
    check("ld_w2_T7", 2, st_log[2][11], 8);
    check("ld_w2_next_T0", 2, st_log[2][12], 1);
    check("ld_w2_pcin", 2, count_bit(2, B_PCIN, 0, 11), 1);
    check("ld_w2_read_T1", 2, count_bit(2, B_READ, 1, 3), 3);
    check("ld_w2_read_T6", 2, count_bit(2, B_READ, 8, 10), 3);
    check("ld_w2_read_total", 2, count_bit(2, B_READ, 0, 11), 6);

    // add
    start({5'd3, 27'h0});
    capture(8);
    check("add_len", 0, st_log[0][6], 1);
    check("add_ADD_cnt", 0, count_bit(0, B_ADD, 0, 5), 1);
    check("add_T4_strobes", 0, sb_log[0][4],
          bt(B_GRC) | bt(B_ROUT) | bt(B_ZIN) | bt(B_ADD));
    check("add_T5_strobes", 0, sb_log[0][5], bt(B_ZLOW) | bt(B_GRA) | bt(B_RIN));

    // st with MEM_WAIT=1
    start({5'd2, 27'h0});
    capture(11);
    check("st_w1_len", 1, st_log[1][10], 1);
    check("st_w1_write", 1, count_bit(1, B_WRITE, 0, 9), 2);
    check("st_w1_read_late", 1, count_bit(1, B_READ, 4, 9), 0);

    // undefined opcode, then halt
    start({5'd31, 27'h0});
    capture(4);
    check("ill_pulse_T2", 0, il_log[0][2], 1);
    check("ill_pulse_cnt", 0, il_log[0][0] + il_log[0][1] + il_log[0][2] + il_log[0][3], 1);
    check("ill_count", 0, ct_log[0][3], 0);
    check("ill_next_T0", 0, st_log[0][3], 1);
    start({5'd27, 27'h0});
    capture(8);
    capture(20);
    c = 0;
    for (int k = 0; k < 20; k++)
      for (int i = 0; i < 3; i++) if (hl_log[i][k] && st_log[i][k] == 4'd15) c++;
    check("halt_hold", 0, c, 60);

    // clear during T6 of ld
    start(32'h00800085);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk); #1;
      if (step_w[0] == 4'd7) found = 1;
    end
    check("ld_T6_reached", 0, found, 1);
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    check("clr_mid_step", 0, step_w[0], 0);
    check("clr_mid_strobes", 0, stb[0], 0);
    check("clr_mid_count", 0, cnt_w[0], 0);

    // five nops wrap a 2-bit counter to 1
    start({5'd24, 27'h0});
    capture(16);
    check("nop_wrap", 0, ct_log[0][15], 1);
    check("nop_len", 0, st_log[0][3], 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      clear = ($urandom_range(0, 79) == 0);
      run   = ($urandom_range(0, 9) != 0);
      c = $urandom_range(0, 99);
      if (c < 3) op = 5'd27;
      else if (c < 8) begin
        op = 5'd31;
        for (int t = 0; t < 64; t++) begin
          op = 5'($urandom_range(0, 31));
          if (!legal(op)) break;
        end
        if (legal(op)) op = 5'd31;
      end else begin
        op = 5'($urandom_range(0, 31));
        while (!legal(op) || op == 5'd27) op = 5'($urandom_range(0, 31));
      end
      IR = {op, 27'($urandom)};
    end
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit datapath. It decodes the opcode field of IR and produces, one state per clock, the datapath strobes for the fetch sequence and the execute sequences of ld, ldi, st, the two-operand ALU ops, neg/not, nop and halt. Memory access latency is set by a parameter rather than fixed at one cycle, and the block keeps a retired-instruction count. It sits between the IR output and the control inputs of the Datapath module.

## Interface
- MEM_WAIT, 0: extra clocks each memory access (Read or Write) is held beyond the first; range 0..15.
- CNT_W, 16: width of the retired-instruction counter.
- clk  input  1  clock; all state changes on the rising edge.
- clear  input  1  synchronous, active-high reset.
- run  input  1  allow the next fetch to start.
- IR  input  32  instruction register; opcode is IR[31:27].
- PCout, PCin, IncPC  output  1 each  PC strobes.
- MARin, MDRin, MDRout, Read, Write  output  1 each  memory-interface strobes.
- IRin, Yin, Zin, Zlowout, Cout, BAout  output  1 each  datapath register and bus strobes.
- Gra, Grb, Grc, Rin, Rout  output  1 each  register-select strobes.
- ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT  output  1 each  ALU op select; at most one high at a time.
- halted  output  1  high while in HALT.
- illegal  output  1  one-cycle pulse on an undefined opcode.
- instr_count  output  CNT_W  instructions retired since clear; wraps.
- step  output  4  current state code, for debug.

## Operation
- Opcodes: ld=0, ldi=1, st=2, add=3, sub=4, shr=5, shl=6, ror=7, rol=8, and=9, or=10, neg=16, not=17, nop=24, halt=27.
- Any other opcode is undefined: pulse illegal in T2, do not retire, then go to the end-of-instruction decision.
- States and step codes: IDLE=0, T0..T7=1..8, HALT=15. Strobe outputs are a Moore decode of state plus the latched opcode.
- IDLE: all strobes 0. Move to T0 when run=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Read and MDRin for 1+MEM_WAIT clocks. Zlowout and PCin only in the first of those clocks.
  - T2: MDRout, IRin. The opcode is latched from the bus image at the end of T2 and decoded in T3.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin for 1+MEM_WAIT clocks.
  - T7: MDRout, Gra, Rin.
- ldi: T3 and T4 as ld; T5: Zlowout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write for 1+MEM_WAIT clocks.
- add/sub/shr/shl/ror/rol/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, plus the op strobe.
  - T5: Zlowout, Gra, Rin.
- neg/not:
  - T3: Grb, Rout, Zin, plus the op strobe.
  - T4: Zlowout, Gra, Rin.
- nop: ends after T2.
- halt: go to HALT after T2. halted=1, all strobes 0. Leave HALT only on clear.
- End of instruction: instr_count increments on the last clock of every ld/ldi/st/ALU/nop instruction. Next state is T0 if run=1, else IDLE.

## Timing
- clear=1 at an edge: next state IDLE, all strobes 0, halted=0, illegal=0, instr_count=0, wait counter=0. This holds mid-instruction, mid-wait and in HALT.
- Cycles per instruction, with W=MEM_WAIT:
  - ld: 8+2W
  - st: 8+2W
  - ldi: 6+W
  - ALU: 6+W
  - neg/not: 5+W
  - nop: 3+W
  - halt: 3+W to reach HALT
- The wait counter loads MEM_WAIT on entry to a memory state and decrements each clock. The state advances when it is 0.
- run is sampled only at the end of an instruction and in IDLE. Dropping run mid-instruction has no effect.
- instr_count wraps from 2^CNT_W−1 to 0.

## Test plan
- MEM_WAIT=0, clear, run=1, IR=32'h00800085 (ld R1,0x85): the T0..T7 strobe sequence matches exactly, ld takes 8 cycles, and instr_count=1 on the clock after T7.
- MEM_WAIT=2, same ld: Read+MDRin held 3 clocks in T1 and 3 in T6, PCin high for 1 clock only, 12 cycles total.
- IR opcode 3 (add): ADD high only in T4 with Grc+Rout+Zin; T5 asserts Gra+Rin; 6 cycles.
- IR opcode 2 (st), MEM_WAIT=1: Write high exactly 2 clocks in T7, and Read never high after T2.
- IR opcode 31: illegal is high 1 clock, instr_count is unchanged, and the next state is T0. Then IR opcode 27: halted=1 and the block stays in HALT with run=1 for 20 clocks.
- clear asserted during T6 of a ld: the next step is 0 with all outputs reset. With CNT_W=2, five nops give instr_count=1.
